// File: rtl/kirby_pkg.sv
// Shared types and constants for the Kirby animation controller.
package kirby_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_WALK   = 2'd1,
    ST_FLOAT  = 2'd2,
    ST_INHALE = 2'd3
  } anim_state_t;

  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_D = 8'h07;
  localparam logic [7:0] KEY_J = 8'h0D;

  // Hitbox extents packed as {L, R, U, B}; element [3] is L.
  typedef logic [3:0][9:0] extent_t;

  // Indexed by frame = {anim_state, sf}.
  localparam extent_t EXTENT_TABLE [8] = '{
    {10'd14, 10'd14, 10'd14, 10'd14},
    {10'd14, 10'd14, 10'd14, 10'd14},
    {10'd14, 10'd14, 10'd14, 10'd14},
    {10'd14, 10'd14, 10'd14, 10'd14},
    {10'd16, 10'd16, 10'd16, 10'd16},
    {10'd16, 10'd16, 10'd16, 10'd16},
    {10'd12, 10'd18, 10'd14, 10'd14},
    {10'd12, 10'd20, 10'd14, 10'd14}
  };

endpackage

// File: rtl/kirby_anim_if.sv
// Key/pixel inputs and animation/sprite outputs of the Kirby animation controller.
interface kirby_anim_if;
  logic [7:0]  keycode;
  logic [9:0]  DrawX, DrawY, KirbyX, KirbyY;
  logic [9:0]  Left_Dis, Right_Dis, Up_Dis, Bottom_Dis;
  logic [1:0]  anim_state;
  logic        facing_left;
  logic [12:0] sprite_addr;
  logic        sprite_valid;

  modport master (
    output keycode, DrawX, DrawY, KirbyX, KirbyY,
    input  Left_Dis, Right_Dis, Up_Dis, Bottom_Dis, anim_state, facing_left,
           sprite_addr, sprite_valid
  );

  modport slave (
    input  keycode, DrawX, DrawY, KirbyX, KirbyY,
    output Left_Dis, Right_Dis, Up_Dis, Bottom_Dis, anim_state, facing_left,
           sprite_addr, sprite_valid
  );
endinterface

// File: rtl/kirby_frame_tick.sv
// Synchronises the asynchronous frame_clk level and emits a one-Clk pulse per rising edge.
module kirby_frame_tick (
  input  logic Clk,
  input  logic Reset_n,
  input  logic frame_clk,
  output logic tick
);

  logic sync1_q, sync1_d;
  logic sync2_q, sync2_d;
  logic prev_q, prev_d;

  always_comb begin
    sync1_d = frame_clk;
    sync2_d = sync1_q;
    prev_d  = sync2_q;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
    end
  end

  assign tick = sync2_q & ~prev_q;

endmodule

// File: rtl/kirby_anim.sv
// Kirby sprite animation FSM, hitbox extents and sprite-ROM address generation.
// Optional KIRBY_ANIM_MIRROR_EN: mirror sprite columns and swap L/R extents when facing left.
module kirby_anim
  import kirby_pkg::*;
#(
  parameter int         FRAME_DIV     = 8,
  parameter int         INHALE_FRAMES = 30,
  parameter logic [7:0] KEY_UP        = KEY_W,
  parameter logic [7:0] KEY_LEFT      = KEY_A,
  parameter logic [7:0] KEY_RIGHT     = KEY_D,
  parameter logic [7:0] KEY_INHALE    = KEY_J
) (
  input  logic         Clk,
  input  logic         Reset_n,
  input  logic         frame_clk,
  kirby_anim_if.slave  bus
);

  logic        tick;
  anim_state_t state_q, state_d, key_state;
  logic        facing_q, facing_d;
  logic        lock_q, lock_d;
  logic [7:0]  inhale_cnt_q, inhale_cnt_d;
  logic [7:0]  sub_cnt_q, sub_cnt_d;
  logic        sf_q, sf_d;
  extent_t     dis_q, dis_d;
  logic [12:0] addr_q, addr_d;
  logic        valid_q, valid_d;
  logic [2:0]  frame;
  logic [9:0]  dx, dy;
  logic [4:0]  col;

  kirby_frame_tick u_frame_tick (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .frame_clk (frame_clk),
    .tick      (tick)
  );

  // A held inhale key after an inhale finishes must not re-trigger until released.
  always_comb begin
    key_state = ST_IDLE;
    if (bus.keycode == KEY_INHALE)
      key_state = lock_q ? ST_IDLE : ST_INHALE;
    else if (bus.keycode == KEY_UP)
      key_state = ST_FLOAT;
    else if (bus.keycode == KEY_LEFT || bus.keycode == KEY_RIGHT)
      key_state = ST_WALK;
  end

  always_comb begin
    state_d      = state_q;
    facing_d     = facing_q;
    lock_d       = lock_q;
    inhale_cnt_d = inhale_cnt_q;
    sub_cnt_d    = sub_cnt_q;
    sf_d         = sf_q;
    if (tick) begin
      if (state_q == ST_INHALE) begin
        if (inhale_cnt_q == 8'd0) begin
          state_d = (bus.keycode == KEY_INHALE) ? ST_IDLE : key_state;
          lock_d  = (bus.keycode == KEY_INHALE);
        end else begin
          inhale_cnt_d = inhale_cnt_q - 8'd1;
          if (bus.keycode != KEY_INHALE) lock_d = 1'b0;
        end
      end else begin
        state_d = key_state;
        if (key_state == ST_INHALE) inhale_cnt_d = 8'(INHALE_FRAMES - 1);
        if (bus.keycode != KEY_INHALE) lock_d = 1'b0;
        if (bus.keycode == KEY_LEFT)       facing_d = 1'b1;
        else if (bus.keycode == KEY_RIGHT) facing_d = 1'b0;
      end
      if (state_d != state_q) begin
        sub_cnt_d = 8'd0;
        sf_d      = 1'b0;
      end else if (sub_cnt_q == 8'(FRAME_DIV - 1)) begin
        sub_cnt_d = 8'd0;
        sf_d      = ~sf_q;
      end else begin
        sub_cnt_d = sub_cnt_q + 8'd1;
      end
    end
  end

  assign frame = {state_q, sf_q};
  assign dx    = bus.DrawX - bus.KirbyX + 10'd16;
  assign dy    = bus.DrawY - bus.KirbyY + 10'd16;

  always_comb begin
    dis_d   = EXTENT_TABLE[frame];
    col     = dx[4:0];
`ifdef KIRBY_ANIM_MIRROR_EN
    if (facing_q) begin
      dis_d[3] = EXTENT_TABLE[frame][2];
      dis_d[2] = EXTENT_TABLE[frame][3];
      col      = 5'd31 - dx[4:0];
    end
`endif
    valid_d = (dx < 10'd32) && (dy < 10'd32);
    addr_d  = valid_d ? {frame, dy[4:0], col} : 13'd0;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= ST_IDLE;
      facing_q     <= 1'b0;
      lock_q       <= 1'b0;
      inhale_cnt_q <= 8'd0;
      sub_cnt_q    <= 8'd0;
      sf_q         <= 1'b0;
      dis_q        <= {10'd14, 10'd14, 10'd14, 10'd14};
      addr_q       <= 13'd0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      facing_q     <= facing_d;
      lock_q       <= lock_d;
      inhale_cnt_q <= inhale_cnt_d;
      sub_cnt_q    <= sub_cnt_d;
      sf_q         <= sf_d;
      dis_q        <= dis_d;
      addr_q       <= addr_d;
      valid_q      <= valid_d;
    end
  end

  assign bus.anim_state   = state_q;
  assign bus.facing_left  = facing_q;
  assign bus.Left_Dis     = dis_q[3];
  assign bus.Right_Dis    = dis_q[2];
  assign bus.Up_Dis       = dis_q[1];
  assign bus.Bottom_Dis   = dis_q[0];
  assign bus.sprite_addr  = addr_q;
  assign bus.sprite_valid = valid_q;

endmodule

// File: tb/tb_kirby_anim.sv
// Directed self-checking bench for kirby_anim; honours KIRBY_ANIM_MIRROR_EN when defined.
module tb_kirby_anim;

`ifdef KIRBY_ANIM_MIRROR_EN
  localparam bit MIRROR = 1'b1;
`else
  localparam bit MIRROR = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Reset_n = 1'b1;
  logic frame_clk = 1'b0;
  int   n_err = 0;
  int   n_chk = 0;
  int   n_tick = 0;

  kirby_anim_if bus();

  kirby_anim #(
    .FRAME_DIV     (8),
    .INHALE_FRAMES (30),
    .KEY_UP        (8'h1A),
    .KEY_LEFT      (8'h04),
    .KEY_RIGHT     (8'h07),
    .KEY_INHALE    (8'h0D)
  ) dut (
    .Clk       (Clk),
    .Reset_n   (Reset_n),
    .frame_clk (frame_clk),
    .bus       (bus)
  );

  always #10 Clk = ~Clk;

  // One frame_clk pulse; returns on a falling Clk edge with Dis settled.
  task automatic do_tick();
    @(negedge Clk) frame_clk = 1'b1;
    repeat (5) @(negedge Clk);
    frame_clk = 1'b0;
    repeat (2) @(negedge Clk);
    n_tick++;
    $display("tick %0d key=%h state=%0d facing=%0b dis=%0d/%0d/%0d/%0d", n_tick, bus.keycode,
             bus.anim_state, bus.facing_left, bus.Left_Dis, bus.Right_Dis, bus.Up_Dis, bus.Bottom_Dis);
  endtask

  task automatic test_reset();
    bus.keycode = 8'h00;
    bus.DrawX = 10'd0; bus.DrawY = 10'd0; bus.KirbyX = 10'd0; bus.KirbyY = 10'd0;
    #5 Reset_n = 1'b0;
    repeat (2) @(negedge Clk);
    n_chk++; if (bus.anim_state !== 2'd0) begin n_err++; $display("FAIL reset_state got=%0d exp=0", bus.anim_state); end
    n_chk++; if (bus.facing_left !== 1'b0) begin n_err++; $display("FAIL reset_facing got=%0b exp=0", bus.facing_left); end
    n_chk++; if ({bus.Left_Dis, bus.Right_Dis, bus.Up_Dis, bus.Bottom_Dis} !== {4{10'd14}}) begin
      n_err++; $display("FAIL reset_dis got=%0d/%0d/%0d/%0d exp=14/14/14/14", bus.Left_Dis, bus.Right_Dis, bus.Up_Dis, bus.Bottom_Dis); end
    n_chk++; if (bus.sprite_valid !== 1'b0 || bus.sprite_addr !== 13'd0) begin
      n_err++; $display("FAIL reset_pixel got valid=%0b addr=%h exp valid=0 addr=0", bus.sprite_valid, bus.sprite_addr); end
    Reset_n = 1'b1;
    repeat (3) do_tick();
    n_chk++; if (bus.anim_state !== 2'd0) begin n_err++; $display("FAIL idle_state got=%0d exp=0", bus.anim_state); end
    n_chk++; if (bus.facing_left !== 1'b0) begin n_err++; $display("FAIL idle_facing got=%0b exp=0", bus.facing_left); end
    n_chk++; if ({bus.Left_Dis, bus.Right_Dis, bus.Up_Dis, bus.Bottom_Dis} !== {4{10'd14}}) begin
      n_err++; $display("FAIL idle_dis got=%0d/%0d/%0d/%0d exp=14/14/14/14", bus.Left_Dis, bus.Right_Dis, bus.Up_Dis, bus.Bottom_Dis); end
    $display("test_reset done");
  endtask

  task automatic test_walk_facing();
    bus.keycode = 8'h07; do_tick();
    n_chk++; if (bus.anim_state !== 2'd1 || bus.facing_left !== 1'b0) begin
      n_err++; $display("FAIL walk_right got state=%0d facing=%0b exp state=1 facing=0", bus.anim_state, bus.facing_left); end
    bus.keycode = 8'h04; do_tick();
    n_chk++; if (bus.anim_state !== 2'd1 || bus.facing_left !== 1'b1) begin
      n_err++; $display("FAIL walk_left got state=%0d facing=%0b exp state=1 facing=1", bus.anim_state, bus.facing_left); end
    bus.keycode = 8'h07; do_tick();
    n_chk++; if (bus.facing_left !== 1'b0) begin n_err++; $display("FAIL walk_turn got facing=%0b exp=0", bus.facing_left); end
    // A key change between ticks must not act before the next tick.
    bus.keycode = 8'h1A;
    repeat (6) @(negedge Clk);
    n_chk++; if (bus.anim_state !== 2'd1) begin n_err++; $display("FAIL no_tick_hold got=%0d exp=1", bus.anim_state); end
    bus.keycode = 8'h00; do_tick();
    n_chk++; if (bus.anim_state !== 2'd0) begin n_err++; $display("FAIL walk_release got=%0d exp=0", bus.anim_state); end
    $display("test_walk_facing done");
  endtask

  task automatic test_inhale_float();
    logic [9:0] exp_r;
    bus.keycode = 8'h0D; do_tick();
    n_chk++; if ({bus.anim_state, bus.Left_Dis, bus.Right_Dis, bus.Up_Dis, bus.Bottom_Dis} !== {2'd3, 10'd12, 10'd18, 10'd14, 10'd14}) begin
      n_err++; $display("FAIL inhale_entry got state=%0d dis=%0d/%0d/%0d/%0d exp state=3 dis=12/18/14/14",
                        bus.anim_state, bus.Left_Dis, bus.Right_Dis, bus.Up_Dis, bus.Bottom_Dis); end
    bus.keycode = 8'h1A;
    for (int k = 1; k <= 29; k++) begin
      do_tick();
      exp_r = (((k / 8) % 2) == 1) ? 10'd20 : 10'd18;
      n_chk++; if (bus.anim_state !== 2'd3 || bus.Left_Dis !== 10'd12 || bus.Right_Dis !== exp_r) begin
        n_err++; $display("FAIL inhale_hold k=%0d got state=%0d L=%0d R=%0d exp state=3 L=12 R=%0d",
                          k, bus.anim_state, bus.Left_Dis, bus.Right_Dis, exp_r); end
    end
    do_tick();
    n_chk++; if ({bus.anim_state, bus.Left_Dis, bus.Right_Dis, bus.Up_Dis, bus.Bottom_Dis} !== {2'd2, {4{10'd16}}}) begin
      n_err++; $display("FAIL inhale_to_float got state=%0d dis=%0d/%0d/%0d/%0d exp state=2 dis=16/16/16/16",
                        bus.anim_state, bus.Left_Dis, bus.Right_Dis, bus.Up_Dis, bus.Bottom_Dis); end
    $display("test_inhale_float done");
  endtask

  task automatic test_inhale_retrigger();
    bus.keycode = 8'h0D;
    repeat (30) do_tick();
    n_chk++; if (bus.anim_state !== 2'd3) begin n_err++; $display("FAIL held_last got=%0d exp=3", bus.anim_state); end
    do_tick();
    n_chk++; if (bus.anim_state !== 2'd0) begin n_err++; $display("FAIL held_exit got=%0d exp=0", bus.anim_state); end
    do_tick();
    n_chk++; if (bus.anim_state !== 2'd0) begin n_err++; $display("FAIL no_retrigger got=%0d exp=0", bus.anim_state); end
    bus.keycode = 8'h00; do_tick();
    bus.keycode = 8'h0D; do_tick();
    n_chk++; if (bus.anim_state !== 2'd3) begin n_err++; $display("FAIL retrigger got=%0d exp=3", bus.anim_state); end
    bus.keycode = 8'h00;
    repeat (30) do_tick();
    n_chk++; if (bus.anim_state !== 2'd0) begin n_err++; $display("FAIL retrigger_exit got=%0d exp=0", bus.anim_state); end
    $display("test_inhale_retrigger done");
  endtask

  task automatic test_facing_pixel();
    logic [9:0]  exp_l, exp_r;
    logic [12:0] exp_addr;
    bus.keycode = 8'h04; do_tick();
    bus.keycode = 8'h0D; do_tick();
    exp_l = MIRROR ? 10'd18 : 10'd12;
    exp_r = MIRROR ? 10'd12 : 10'd18;
    n_chk++; if (bus.facing_left !== 1'b1 || bus.Left_Dis !== exp_l || bus.Right_Dis !== exp_r) begin
      n_err++; $display("FAIL inhale_left_dis got facing=%0b L=%0d R=%0d exp facing=1 L=%0d R=%0d",
                        bus.facing_left, bus.Left_Dis, bus.Right_Dis, exp_l, exp_r); end
    bus.keycode = 8'h07; do_tick();
    n_chk++; if (bus.facing_left !== 1'b1 || bus.anim_state !== 2'd3) begin
      n_err++; $display("FAIL facing_frozen got facing=%0b state=%0d exp facing=1 state=3", bus.facing_left, bus.anim_state); end
    // frame = {INHALE, sf=0} = 6, dx=0, dy=16
    @(negedge Clk);
    bus.KirbyX = 10'd100; bus.KirbyY = 10'd100; bus.DrawX = 10'd84; bus.DrawY = 10'd100;
    @(posedge Clk); #1;
    exp_addr = MIRROR ? {3'd6, 5'd16, 5'd31} : {3'd6, 5'd16, 5'd0};
    n_chk++; if (bus.sprite_valid !== 1'b1 || bus.sprite_addr !== exp_addr) begin
      n_err++; $display("FAIL pixel_left_edge got valid=%0b addr=%h exp valid=1 addr=%h", bus.sprite_valid, bus.sprite_addr, exp_addr); end
    @(negedge Clk); bus.DrawX = 10'd116;
    @(posedge Clk); #1;
    n_chk++; if (bus.sprite_valid !== 1'b0 || bus.sprite_addr !== 13'd0) begin
      n_err++; $display("FAIL pixel_outside got valid=%0b addr=%h exp valid=0 addr=0", bus.sprite_valid, bus.sprite_addr); end
    @(negedge Clk); bus.KirbyX = 10'd5; bus.DrawX = 10'd0;
    @(posedge Clk); #1;
    exp_addr = MIRROR ? {3'd6, 5'd16, 5'd20} : {3'd6, 5'd16, 5'd11};
    n_chk++; if (bus.sprite_valid !== 1'b1 || bus.sprite_addr !== exp_addr) begin
      n_err++; $display("FAIL pixel_wrap got valid=%0b addr=%h exp valid=1 addr=%h", bus.sprite_valid, bus.sprite_addr, exp_addr); end
    bus.keycode = 8'h00;
    repeat (29) do_tick();
    n_chk++; if (bus.anim_state !== 2'd0 || bus.facing_left !== 1'b1) begin
      n_err++; $display("FAIL left_inhale_exit got state=%0d facing=%0b exp state=0 facing=1", bus.anim_state, bus.facing_left); end
    $display("test_facing_pixel done");
  endtask

  task automatic test_reset_mid_inhale();
    bus.KirbyX = 10'd200; bus.KirbyY = 10'd200; bus.DrawX = 10'd200; bus.DrawY = 10'd200;
    bus.keycode = 8'h0D; do_tick();
    bus.keycode = 8'h00;
    repeat (10) do_tick();
    n_chk++; if (bus.anim_state !== 2'd3 || bus.sprite_valid !== 1'b1) begin
      n_err++; $display("FAIL pre_reset got state=%0d valid=%0b exp state=3 valid=1", bus.anim_state, bus.sprite_valid); end
    @(negedge Clk); #2 Reset_n = 1'b0;
    #1;
    n_chk++; if (bus.anim_state !== 2'd0 || bus.facing_left !== 1'b0) begin
      n_err++; $display("FAIL async_reset_state got state=%0d facing=%0b exp state=0 facing=0", bus.anim_state, bus.facing_left); end
    n_chk++; if ({bus.Left_Dis, bus.Right_Dis, bus.Up_Dis, bus.Bottom_Dis} !== {4{10'd14}} ||
                 bus.sprite_valid !== 1'b0 || bus.sprite_addr !== 13'd0) begin
      n_err++; $display("FAIL async_reset_out got dis=%0d/%0d/%0d/%0d valid=%0b addr=%h exp dis=14/14/14/14 valid=0 addr=0",
                        bus.Left_Dis, bus.Right_Dis, bus.Up_Dis, bus.Bottom_Dis, bus.sprite_valid, bus.sprite_addr); end
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
    bus.keycode = 8'h0D; do_tick();
    n_chk++; if (bus.anim_state !== 2'd3) begin n_err++; $display("FAIL reentry got=%0d exp=3", bus.anim_state); end
    bus.keycode = 8'h1A;
    repeat (29) do_tick();
    n_chk++; if (bus.anim_state !== 2'd3) begin n_err++; $display("FAIL reentry_len got=%0d exp=3", bus.anim_state); end
    do_tick();
    n_chk++; if (bus.anim_state !== 2'd2) begin n_err++; $display("FAIL reentry_exit got=%0d exp=2", bus.anim_state); end
    $display("test_reset_mid_inhale done");
  endtask

  initial begin
    test_reset();
    test_walk_facing();
    test_inhale_float();
    test_inhale_retrigger();
    test_facing_pixel();
    test_reset_mid_inhale();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
